// File: rtl/bram_flash_mem.sv
// -----------------------------------------------------------------------------
// bram_flash_mem
//
// Memory block behind the CPU load/store path. Decodes a 32-bit byte address
// into one of two windows, a single-port 32-bit block RAM and a small NOR-style
// flash model, and services one single-word read, write/program or erase per
// cycle. Illegal requests produce a one-cycle registered error pulse and have
// no other effect.
//
// Flash behaviour: bits can only be cleared by a program (word &= data) and
// set back to 1 by an erase. Program and erase are multi-cycle operations
// reported on busy. The array update happens atomically in the final busy
// cycle, so a reset during an operation leaves the array untouched.
//
// Build option:
//   FLASH_SECTOR_ERASE_EN  defined   : erase clears the SECTOR_BYTES sector
//                                       that contains addr.
//                          undefined : erase clears the whole flash array
//                                       (addr must still decode to flash).
//
// Ports:
//   clk        in   1   single clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   rd_en      in   1   read request this cycle
//   wr_en      in   1   write (BRAM) / program (flash) request this cycle
//   erase_en   in   1   flash erase request this cycle
//   addr       in  32   byte address, must be word aligned
//   idata      in  32   write/program data
//   odata      out 32   registered read data, changes only on a good read
//   bram_sel   out  1   combinational: addr inside the BRAM window
//   flash_sel  out  1   combinational: addr inside the flash window
//   busy       out  1   flash program/erase in progress
//   error      out  1   one-cycle registered error pulse
// -----------------------------------------------------------------------------
module bram_flash_mem #(
  parameter logic [31:0] BRAM_BASE    = 32'h0000_0000,
  parameter int          BRAM_AW      = 16,
  parameter logic [31:0] FLASH_BASE   = 32'h1000_0000,
  parameter int          FLASH_AW     = 12,
  parameter int          PROG_CYCLES  = 4,
  parameter int          ERASE_CYCLES = 16,
  parameter int          SECTOR_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        erase_en,
  input  logic [31:0] addr,
  input  logic [31:0] idata,
  output logic [31:0] odata,
  output logic        bram_sel,
  output logic        flash_sel,
  output logic        busy,
  output logic        error
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int BRAM_WORDS   = 2 ** (BRAM_AW - 2);
  localparam int FLASH_WORDS  = 2 ** (FLASH_AW - 2);
  localparam int SECTOR_WORDS = SECTOR_BYTES / 4;
  localparam int NUM_SECTORS  = FLASH_WORDS / SECTOR_WORDS;

  // Window masks keep only the address bits above the window offset, so the
  // compare against the base covers the full 32-bit address.
  localparam logic [31:0] BRAM_MASK  = ~((32'd1 << BRAM_AW) - 32'd1);
  localparam logic [31:0] FLASH_MASK = ~((32'd1 << FLASH_AW) - 32'd1);

  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter runs from LOAD down to zero, so the op stays busy for
  // exactly *_CYCLES cycles and commits on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROG  = 2'd1,
    ST_ERASE = 2'd2
  } flash_state_e;

  // ---------------------------------------------------------------------------
  // Storage arrays
  // ---------------------------------------------------------------------------
  logic [31:0] bram_mem  [BRAM_WORDS];
  logic [31:0] flash_mem [FLASH_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [BRAM_AW-3:0]  bram_idx;
  logic [FLASH_AW-3:0] flash_idx;

  assign bram_sel  = (addr & BRAM_MASK)  == BRAM_BASE;
  assign flash_sel = (addr & FLASH_MASK) == FLASH_BASE;
  assign bram_idx  = addr[BRAM_AW-1:2];
  assign flash_idx = addr[FLASH_AW-1:2];

  // ---------------------------------------------------------------------------
  // Request validation
  // ---------------------------------------------------------------------------
  logic req;
  logic multi_req;
  logic err_d;
  logic req_ok;
  logic bram_rd;
  logic bram_wr;
  logic flash_rd;
  logic flash_prog;
  logic flash_erase;

  assign req       = rd_en | wr_en | erase_en;
  assign multi_req = (rd_en & wr_en) | (rd_en & erase_en) | (wr_en & erase_en);

  // Any flash access while an op is in flight is refused, including reads:
  // the array is mid-operation and its contents are not yet defined.
  assign err_d = req & (~(bram_sel | flash_sel)
                        | (addr[1:0] != 2'b00)
                        | multi_req
                        | (erase_en & bram_sel)
                        | (flash_sel & busy));

  assign req_ok      = req & ~err_d;
  assign bram_rd     = req_ok & bram_sel  & rd_en;
  assign bram_wr     = req_ok & bram_sel  & wr_en;
  assign flash_rd    = req_ok & flash_sel & rd_en;
  assign flash_prog  = req_ok & flash_sel & wr_en;
  assign flash_erase = req_ok & flash_sel & erase_en;

  // ---------------------------------------------------------------------------
  // Flash FSM: state register
  // ---------------------------------------------------------------------------
  flash_state_e        state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [FLASH_AW-3:0] op_idx_q,  op_idx_d;
  logic [31:0]         op_data_q, op_data_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_idx_q  <= '0;
      op_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_idx_q  <= op_idx_d;
      op_data_q <= op_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Flash FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold value first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_idx_d  = op_idx_q;
    op_data_d = op_data_q;
    case (state_q)
      ST_IDLE: begin
        if (flash_prog) begin
          state_d   = ST_PROG;
          cnt_d     = PROG_LOAD;
          op_idx_d  = flash_idx;
          op_data_d = idata;
        end else if (flash_erase) begin
          state_d  = ST_ERASE;
          cnt_d    = ERASE_LOAD;
          op_idx_d = flash_idx;
        end
      end
      ST_PROG, ST_ERASE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Flash FSM: outputs
  // ---------------------------------------------------------------------------
  logic prog_commit;
  logic erase_commit;

  always_comb begin
    busy         = (state_q != ST_IDLE);
    prog_commit  = (state_q == ST_PROG)  && (cnt_q == '0);
    erase_commit = (state_q == ST_ERASE) && (cnt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Erase target selection
  // ---------------------------------------------------------------------------
  logic [NUM_SECTORS-1:0] erase_sector_hit;

`ifdef FLASH_SECTOR_ERASE_EN
  // Only the sector holding the latched target word is cleared.
  always_comb begin
    erase_sector_hit = '0;
    for (int s = 0; s < NUM_SECTORS; s++) begin
      erase_sector_hit[s] = ((int'(op_idx_q) / SECTOR_WORDS) == s);
    end
  end
`else
  // Whole-array erase: every sector is a target, the address offset is unused.
  assign erase_sector_hit = '1;
`endif

  // ---------------------------------------------------------------------------
  // Array updates
  // ---------------------------------------------------------------------------
  // NOTE: the arrays have no reset; their contents survive rst by design and
  // a reset branch would also stop them mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (bram_wr) begin
      bram_mem[bram_idx] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_commit) begin
      // NOR program can only clear bits.
      flash_mem[op_idx_q] <= flash_mem[op_idx_q] & op_data_q;
    end else if (erase_commit) begin
      for (int s = 0; s < NUM_SECTORS; s++) begin
        if (erase_sector_hit[s]) begin
          for (int w = 0; w < SECTOR_WORDS; w++) begin
            flash_mem[(FLASH_AW-2)'(s * SECTOR_WORDS + w)] <= '1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data and error pulse
  // ---------------------------------------------------------------------------
  logic [31:0] odata_q;
  logic        error_q;

  // odata only moves on an accepted read; writes, errors and idle cycles hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odata_q <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= err_d;
      if (bram_rd) begin
        odata_q <= bram_mem[bram_idx];
      end else if (flash_rd) begin
        odata_q <= flash_mem[flash_idx];
      end
    end
  end

  assign odata = odata_q;
  assign error = error_q;

endmodule

// File: tb/tb_bram_flash_mem.sv
module tb_bram_flash_mem;

  localparam logic [31:0] BRAM_BASE    = 32'h0000_0000;
  localparam longint      BRAM_BYTES   = 64'd65536;
  localparam logic [31:0] FLASH_BASE   = 32'h1000_0000;
  localparam longint      FLASH_BYTES  = 64'd4096;
  localparam int          FLASH_WORDS  = 1024;
  localparam int          SECTOR_WORDS = 64;
  localparam int          PROG_CYCLES  = 4;
  localparam int          ERASE_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic        erase_en;
  logic [31:0] addr;
  logic [31:0] idata;
  logic [31:0] odata;
  logic        bram_sel;
  logic        flash_sel;
  logic        busy;
  logic        error;

  bram_flash_mem dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .erase_en  (erase_en),
    .addr      (addr),
    .idata     (idata),
    .odata     (odata),
    .bram_sel  (bram_sel),
    .flash_sel (flash_sel),
    .busy      (busy),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Reference model state
  logic [31:0] bram_m [int];
  logic [31:0] flash_m [FLASH_WORDS];
  int          busy_left;
  bit          pend_erase;
  int          pend_idx;
  logic [31:0] pend_data;
  logic [31:0] exp_odata;
  logic        exp_err;
  logic        exp_busy;
  logic        exp_bsel;
  logic        exp_fsel;
  logic        s_bsel;
  logic        s_fsel;

  task automatic commit_pending();
    if (pend_erase) begin
      for (int i = 0; i < FLASH_WORDS; i++) begin
`ifdef FLASH_SECTOR_ERASE_EN
        if (i / SECTOR_WORDS == pend_idx / SECTOR_WORDS) flash_m[i] = 32'hFFFF_FFFF;
`else
        flash_m[i] = 32'hFFFF_FFFF;
`endif
      end
    end else begin
      flash_m[pend_idx] = flash_m[pend_idx] & pend_data;
    end
  endtask

  // Drives one request for one clock cycle and advances the model. Starts and
  // ends at a falling edge; registered outputs are then stable for checking.
  task automatic step(input logic r, input logic w, input logic e,
                      input logic [31:0] a, input logic [31:0] d);
    longint boff, foff;
    logic   b, f, err;
    int     nreq;
    rd_en = r; wr_en = w; erase_en = e; addr = a; idata = d;
    #1;
    s_bsel = bram_sel;
    s_fsel = flash_sel;
    boff = longint'(a) - longint'(BRAM_BASE);
    foff = longint'(a) - longint'(FLASH_BASE);
    b = (boff >= 0) && (boff < BRAM_BYTES);
    f = (foff >= 0) && (foff < FLASH_BYTES);
    nreq = int'(r) + int'(w) + int'(e);
    err = (nreq > 0) && (!(b || f) || (a[1:0] != 2'b00) || (nreq > 1)
                         || (e && b) || (f && busy_left > 0));
    @(posedge clk);
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) commit_pending();
    end
    if (nreq > 0 && !err) begin
      if (b) begin
        if (r) exp_odata = bram_m[int'(boff / 4)];
        else   bram_m[int'(boff / 4)] = d;
      end else if (r) begin
        exp_odata = flash_m[int'(foff / 4)];
      end else begin
        pend_erase = e;
        pend_idx   = int'(foff / 4);
        pend_data  = d;
        busy_left  = e ? ERASE_CYCLES : PROG_CYCLES;
      end
    end
    exp_err  = err;
    exp_busy = (busy_left > 0);
    exp_bsel = b;
    exp_fsel = f;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Counts busy cycles (including the one right after the request), bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; erase_en = 1'b0;
    addr = 32'h0; idata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (odata !== 32'h0) begin n_fail++; $display("FAIL reset_odata: got %h want %h", odata, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_checks++; if ({bram_sel, flash_sel} !== 2'b10) begin n_fail++; $display("FAIL reset_decode: got %b want 10", {bram_sel, flash_sel}); end
    rst = 1'b0;
    busy_left = 0; exp_odata = 32'h0; exp_err = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic test_bram();
    step(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    n_checks++; if ({error, s_bsel, s_fsel} !== 3'b010) begin n_fail++; $display("FAIL bram_wr_flags: got %b want 010", {error, s_bsel, s_fsel}); end
    n_checks++; if (odata !== 32'h0) begin n_fail++; $display("FAIL bram_wr_hold: got %h want %h", odata, 32'h0); end
    step(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    n_checks++; if (odata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bram_rd: got %h want %h", odata, 32'hDEAD_BEEF); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL bram_rd_err: got %b want 0", error); end
    // Top word of the window, read back on the very next cycle
    step(1'b0, 1'b1, 1'b0, 32'h0000_FFFC, 32'hA5A5_5A5A);
    step(1'b1, 1'b0, 1'b0, 32'h0000_FFFC, 32'h0);
    n_checks++; if (odata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL bram_top_word: got %h want %h", odata, 32'hA5A5_5A5A); end
    step(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0123_4567);
    // First byte past the window
    step(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
    n_checks++; if ({error, s_bsel} !== 2'b10) begin n_fail++; $display("FAIL bram_past_end: got %b want 10", {error, s_bsel}); end
    n_checks++; if (odata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL bram_past_end_hold: got %h want %h", odata, 32'hA5A5_5A5A); end
  endtask

  task automatic test_decode();
    step(1'b1, 1'b0, 1'b0, 32'h2000_0000, 32'h0);
    n_checks++; if ({s_bsel, s_fsel} !== 2'b00) begin n_fail++; $display("FAIL decode_unmapped_sel: got %b want 00", {s_bsel, s_fsel}); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL decode_unmapped_err: got %b want 1", error); end
    n_checks++; if (odata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL decode_odata_hold: got %h want %h", odata, 32'hA5A5_5A5A); end
    idle();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL decode_err_pulse: got %b want 0", error); end
    step(1'b0, 1'b0, 1'b0, 32'h1000_0FFC, 32'h0);
    n_checks++; if ({s_bsel, s_fsel} !== 2'b01) begin n_fail++; $display("FAIL decode_flash_top: got %b want 01", {s_bsel, s_fsel}); end
    step(1'b0, 1'b0, 1'b0, 32'h1000_1000, 32'h0);
    n_checks++; if ({s_bsel, s_fsel, error} !== 3'b000) begin n_fail++; $display("FAIL decode_flash_past: got %b want 000", {s_bsel, s_fsel, error}); end
  endtask

  task automatic test_flash();
    int n;
    step(1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL flash_erase_err: got %b want 0", error); end
    count_busy(n);
    n_checks++; if (n !== ERASE_CYCLES) begin n_fail++; $display("FAIL flash_erase_busy: got %0d cycles want %0d", n, ERASE_CYCLES); end
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if (odata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flash_erased: got %h want %h", odata, 32'hFFFF_FFFF); end
    step(1'b0, 1'b1, 1'b0, 32'h1000_0004, 32'h0000_00FF);
    count_busy(n);
    n_checks++; if (n !== PROG_CYCLES) begin n_fail++; $display("FAIL flash_prog_busy: got %0d cycles want %0d", n, PROG_CYCLES); end
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if (odata !== 32'h0000_00FF) begin n_fail++; $display("FAIL flash_prog1: got %h want %h", odata, 32'h0000_00FF); end
    step(1'b0, 1'b1, 1'b0, 32'h1000_0004, 32'hFFFF_0F0F);
    count_busy(n);
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if (odata !== 32'h0000_000F) begin n_fail++; $display("FAIL flash_prog_and: got %h want %h", odata, 32'h0000_000F); end
  endtask

  task automatic test_busy();
    int guard;
    step(1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if ({error, busy} !== 2'b11) begin n_fail++; $display("FAIL busy_flash_rd: got %b want 11", {error, busy}); end
    n_checks++; if (odata !== 32'h0000_000F) begin n_fail++; $display("FAIL busy_odata_hold: got %h want %h", odata, 32'h0000_000F); end
    step(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    n_checks++; if ({error, odata} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL busy_bram_rd: got %b/%h want 0/%h", error, odata, 32'hDEAD_BEEF); end
    step(1'b0, 1'b1, 1'b0, 32'h1000_0008, 32'h0);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL busy_flash_prog: got %b want 1", error); end
    guard = 0;
    while (busy_left > 1 && guard < 100) begin guard++; idle(); end
    // Last busy cycle: still refused
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL busy_last_cycle: got %b want 1", error); end
    // Cycle after busy falls: accepted
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if ({error, busy, odata} !== {2'b00, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL busy_release: got %b%b/%h want 00/%h", error, busy, odata, 32'hFFFF_FFFF); end
  endtask

  task automatic test_protocol();
    step(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hBAD0_BAD0);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL proto_rd_wr: got %b want 1", error); end
    step(1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'hBAD0_BAD0);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL proto_misaligned: got %b want 1", error); end
    step(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0);
    n_checks++; if (odata !== 32'h0123_4567) begin n_fail++; $display("FAIL proto_mem_intact: got %h want %h", odata, 32'h0123_4567); end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    n_checks++; if ({error, busy} !== 2'b10) begin n_fail++; $display("FAIL proto_bram_erase: got %b want 10", {error, busy}); end
    step(1'b0, 1'b1, 1'b1, 32'h1000_0004, 32'h0);
    n_checks++; if ({error, busy} !== 2'b10) begin n_fail++; $display("FAIL proto_wr_erase: got %b want 10", {error, busy}); end
    step(1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
    n_checks++; if (odata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL proto_flash_intact: got %h want %h", odata, 32'hFFFF_FFFF); end
  endtask

  task automatic test_reset_mid_erase();
    int n;
    step(1'b0, 1'b1, 1'b0, 32'h1000_0008, 32'h1234_5678);
    count_busy(n);
    step(1'b1, 1'b0, 1'b0, 32'h1000_0008, 32'h0);
    n_checks++; if (odata !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_pre_read: got %h want %h", odata, 32'h1234_5678); end
    step(1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
    repeat (4) idle();
    rst = 1'b1;
    #1;
    n_checks++; if ({busy, error, odata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL rst_mid_erase: got %b%b/%h want 00/%h", busy, error, odata, 32'h0); end
    busy_left = 0; exp_odata = 32'h0; exp_err = 1'b0; exp_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h1000_0008, 32'h0);
    n_checks++; if (odata !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_flash_intact: got %h want %h", odata, 32'h1234_5678); end
    step(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    n_checks++; if (odata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_bram_intact: got %h want %h", odata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_random();
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    // Seed a small BRAM pool so every random read hits a known word
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 32'h0000_0040 + 32'(4 * i), $urandom);
    for (int it = 0; it < 500; it++) begin
      k = int'($urandom_range(0, 99));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'h0000_0040 + 32'(4 * $urandom_range(0, 15));
      else                           a = FLASH_BASE + 32'(4 * $urandom_range(0, 15));
      if      (k < 40) step(1'b1, 1'b0, 1'b0, a, d);
      else if (k < 70) step(1'b0, 1'b1, 1'b0, a, d);
      else if (k < 74) step(1'b0, 1'b0, 1'b1, a, d);
      else if (k < 85) step(1'b0, 1'b0, 1'b0, a, d);
      else if (k < 90) step(1'b1, 1'b1, 1'b0, a, d);
      else if (k < 95) step(1'b1, 1'b0, 1'b0, a | 32'h2, d);
      else             step(1'b1, 1'b0, 1'b0, 32'h2000_0000 | a, d);
      n_checks++;
      if ({odata, error, busy, s_bsel, s_fsel} !== {exp_odata, exp_err, exp_busy, exp_bsel, exp_fsel}) begin
        n_fail++;
        $display("FAIL random[%0d] addr=%h: got odata=%h err=%b busy=%b sel=%b%b want odata=%h err=%b busy=%b sel=%b%b",
                 it, a, odata, error, busy, s_bsel, s_fsel, exp_odata, exp_err, exp_busy, exp_bsel, exp_fsel);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bram();
    test_decode();
    test_flash();
    test_busy();
    test_protocol();
    test_reset_mid_erase();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
